me_ctrl: RTL
============

Name: me_ctrl

Overview:
- Memory-stage access sequencer. It sits beside the ME pipeline register and drives the external data-memory bus for loads and stores.
- It stalls the upstream pipeline while a bus transaction is outstanding.
- It returns aligned, sign- or zero-extended load data to the writeback path.
- It flags misaligned accesses without issuing a bus cycle.

Parameters:
- ADDR_W, 32, byte-address width (matches codebase ADDR_W).
- WORD_W, 32, data width. Fixed at 32; 4 byte lanes.
- TIMEOUT_CYC, 255, maximum REQ cycles before a bus error. Used only with ME_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge
- clr_n  in  1  asynchronous active-low reset
- i_valid  in  1  ME stage holds a live instruction
- i_load  in  1  instruction is a load
- i_store  in  1  instruction is a store. i_load and i_store are never both 1.
- i_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- i_sign  in  1  sign-extend load result when 1
- i_addr  in  ADDR_W  byte address (ALU result)
- i_wdata  in  WORD_W  store data, low-aligned
- o_stall  out  1  hold IF/ID/EX/ME registers
- o_rdata  out  WORD_W  extended load result
- o_rdata_valid  out  1  one-cycle pulse with load result
- o_done  out  1  one-cycle pulse, any access completed
- o_misalign  out  1  one-cycle pulse, misaligned access rejected
- o_bus_err  out  1  one-cycle pulse, bus timeout
- o_mem_req  out  1  bus request
- o_mem_we  out  1  write strobe
- o_mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  WORD_W  lane-replicated store data
- i_mem_ack  in  1  bus acknowledge, one cycle per request
- i_mem_rdata  in  WORD_W  read data, valid with ack

Behaviour:
- Reset: clk single clock; clr_n asynchronous, active-low.
  - clr_n low forces IDLE immediately.
  - All outputs go to 0, including o_mem_req and o_stall. o_rdata=0.
  - Reset mid-REQ abandons the transaction; a later ack is ignored.
- Access: acc = i_valid & (i_load | i_store).
- Misalignment:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]≠0 is misaligned.
  - byte is never misaligned.
- States: IDLE, REQ, DONE.
- IDLE:
  - acc & misaligned: o_misalign=1 this cycle, o_stall=0, no bus cycle, stay IDLE.
  - acc & aligned: o_stall=1 combinationally this cycle. At the edge, register addr/be/wdata/we/size/sign/addr[1:0] and go to REQ.
  - otherwise: no action.
- REQ:
  - o_mem_req=1 and o_stall=1. All bus outputs are held stable from registers.
  - i_mem_ack sampled high: latch i_mem_rdata and go to DONE.
  - Ack in the first REQ cycle is legal.
- DONE:
  - o_stall=0, o_done=1.
  - o_rdata_valid=1 for loads only; o_rdata holds the extended value.
  - Unconditionally return to IDLE. The held ME instruction is not relaunched.
- Latency: minimum stall is 2 cycles (IDLE + one REQ); result appears 2 cycles after presentation.
- Byte enables:
  - byte: 1<<a[1:0]
  - half: a[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data lanes:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Read extraction: select the lane by the registered a[1:0]. Extend to 32 bits with bit 7 or bit 15 when i_sign=1, else zero-fill.
- Outside REQ: i_mem_ack is ignored. o_rdata retains its last value outside DONE.

Optional Feature:
- Macro ME_CTRL_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYC: drop o_mem_req, pulse o_bus_err in DONE, o_rdata=0, o_rdata_valid=0, o_done=1.
  - Ack arriving on the timeout cycle takes priority over the timeout.
- Not defined: REQ waits indefinitely; o_bus_err is tied 0; no counter logic.

Test Plan:
- Word load at addr 0x100, memory acks on 1st REQ cycle with 0xDEADBEEF:
  - o_mem_addr=0x100, be=4'hF, we=0.
  - o_stall high exactly 2 cycles.
  - DONE: o_rdata=0xDEADBEEF, o_rdata_valid=1.
- Signed byte load at 0x103, rdata 0x80FFFFFF, ack after 3 wait cycles:
  - be=4'b1000.
  - o_rdata=0xFFFFFF80 with i_sign=1; 0x00000080 with i_sign=0.
  - Stall lasts 5 cycles.
- Half store 0x1234ABCD at 0x202:
  - o_mem_addr=0x200, be=4'b1100, we=1, o_mem_wdata=0xABCDABCD.
  - o_done pulses; o_rdata_valid stays 0.
- Word load at 0x101:
  - o_misalign pulses one cycle, o_stall=0, o_mem_req never asserted.
- clr_n low during REQ:
  - o_mem_req and o_stall drop without waiting for a clock edge.
  - Ack after release is ignored; next access behaves normally.
- With ME_CTRL_TIMEOUT_EN, TIMEOUT_CYC=4, no ack:
  - o_mem_req drops after 4 REQ cycles.
  - o_bus_err=1, o_done=1, o_rdata=0.
  - Back to IDLE next cycle.

Source files
------------

// File: rtl/me_ctrl.sv
// Memory-stage access sequencer: issues one bus cycle per load/store, stalls the pipe until ack.
// Optional bus timeout is enabled by defining ME_CTRL_TIMEOUT_EN (adds TIMEOUT_CYC parameter).
module me_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32
`ifdef ME_CTRL_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              i_valid,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_stall,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_done,
    output logic              o_misalign,
    output logic              o_bus_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  off_q;

    logic        acc;
    logic        mis;
    logic        launch;
    logic [3:0]  be_d;
    logic [WORD_W-1:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [WORD_W-1:0] rdata_ext;

`ifdef ME_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt;
`else
    assign o_bus_err = 1'b0;
`endif

    // Handshake: the ME instruction is consumed on the first cycle with i_valid=1 and
    // o_stall=0; while o_stall=1 upstream must hold i_valid and all request fields.
    assign acc    = i_valid & (i_load | i_store);
    assign mis    = ((i_size == 2'd1) & i_addr[0]) | (i_size[1] & (|i_addr[1:0]));
    assign launch = (state == S_IDLE) & acc & ~mis;

    assign o_stall     = clr_n & (launch | (state == S_REQ));
    assign o_misalign  = clr_n & (state == S_IDLE) & acc & mis;
    assign o_dbg_state = state;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = i_wdata;
        case (i_size)
            2'd0: begin
                be_d    = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                be_d    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{i_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = i_wdata;
            end
        endcase
    end

    // Lane selection uses the offset captured at launch, not the live address.
    assign byte_sel = i_mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        rdata_ext = i_mem_rdata;
        case (size_q)
            2'd0:    rdata_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'd1:    rdata_ext = {{16{sign_q & half_sel[15]}}, half_sel};
            default: rdata_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state         <= S_IDLE;
            size_q        <= 2'd0;
            sign_q        <= 1'b0;
            off_q         <= 2'd0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_done        <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_be      <= 4'b0;
            o_mem_wdata   <= '0;
`ifdef ME_CTRL_TIMEOUT_EN
            o_bus_err     <= 1'b0;
            cnt           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state       <= S_REQ;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_store;
                        o_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                        o_mem_be    <= be_d;
                        o_mem_wdata <= wdata_d;
                        size_q      <= i_size;
                        sign_q      <= i_sign;
                        off_q       <= i_addr[1:0];
`ifdef ME_CTRL_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (i_mem_ack) begin
                        state         <= S_DONE;
                        o_mem_req     <= 1'b0;
                        o_mem_we      <= 1'b0;
                        o_done        <= 1'b1;
                        o_rdata_valid <= ~o_mem_we;
                        if (!o_mem_we) begin
                            o_rdata <= rdata_ext;
                        end
                    end
`ifdef ME_CTRL_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state     <= S_DONE;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                        o_rdata   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    o_done        <= 1'b0;
                    o_rdata_valid <= 1'b0;
`ifdef ME_CTRL_TIMEOUT_EN
                    o_bus_err     <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
